factorial_scheduler: RTL

Round-robin scheduler that shares one `factorial` core among `NUM_REQ` requesters. It accepts one request at a time and range-checks the operand. It sequences the core's `start`/`done` handshake, guards against hangs with a watchdog, and returns the result tagged with the requester ID. It sits between the requesting blocks and a single `factorial` instance clocked and reset from the same `clk`/`rst`.

---
 rtl/factorial_pkg.sv | 10 +
 rtl/factorial_scheduler_rr_arbiter.sv | 27 ++
 rtl/factorial_scheduler.sv | 103 ++++++++++
 3 files changed

// File: rtl/factorial_pkg.sv
// factorial_pkg: shared FSM encoding, error bit positions and sizing defaults for factorial_scheduler
package factorial_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;
    localparam int ERR_OVF     = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int DEF_MAX_N   = 12;
endpackage

// File: rtl/factorial_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [N-1:0]          gnt,
    output logic [$clog2(N)-1:0]  idx,
    output logic                  any
);
    localparam int IW = $clog2(N);
    logic [IW-1:0] k;
    // scan from the farthest offset down so the nearest request to ptr wins
    always_comb begin
        idx = '0;
        any = 1'b0;
        k = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % N);
            if (req[k]) begin
                idx = k;
                any = 1'b1;
            end
        end
        gnt = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/factorial_scheduler.sv
// factorial_scheduler: round-robin front end sharing one factorial core among NUM_REQ requesters
module factorial_scheduler
    import factorial_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int N_WIDTH  = 8,
    parameter int FN_WIDTH = 32,
    parameter int MAX_N    = DEF_MAX_N,
    parameter int TIMEOUT  = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*N_WIDTH-1:0]  req_n,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [FN_WIDTH-1:0]         rsp_fn,
    output logic [1:0]                  rsp_err,
    output logic                        busy,
    output logic                        fact_start,
    output logic [N_WIDTH-1:0]          fact_n,
    input  logic                        fact_done,
    input  logic [FN_WIDTH-1:0]         fact_fn
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [N_WIDTH-1:0] MAX_V   = N_WIDTH'(MAX_N);
    localparam logic [CW-1:0]      CNT_END = CW'(TIMEOUT - 1);
    localparam logic [1:0]         E_OVF   = 2'(1 << ERR_OVF);
    localparam logic [1:0]         E_TO    = 2'(1 << ERR_TIMEOUT);

    logic [1:0]          state;
    logic [IW-1:0]       ptr, id, pick;
    logic [N_WIDTH-1:0]  n, n_pick;
    logic [FN_WIDTH-1:0] fn;
    logic [1:0]          err;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  gnt;
    logic                any;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req(req_valid),
        .ptr(ptr),
        .gnt(gnt),
        .idx(pick),
        .any(any)
    );

    assign n_pick     = req_n[pick*N_WIDTH +: N_WIDTH];
    // ready is qualified by rst so nothing is offered while reset is held
    assign req_ready  = (state == S_IDLE && rst) ? gnt : '0;
    assign busy       = state != S_IDLE;
    assign fact_start = state == S_LAUNCH;
    assign fact_n     = (state == S_LAUNCH || state == S_WAIT) ? n : '0;
    assign rsp_valid  = state == S_RESP;
    assign rsp_id     = rsp_valid ? id : '0;
    assign rsp_fn     = rsp_valid ? fn : '0;
    assign rsp_err    = rsp_valid ? err : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ptr   <= '0;
            id    <= '0;
            n     <= '0;
            fn    <= '0;
            err   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (any) begin
                    id  <= pick;
                    n   <= n_pick;
                    fn  <= '0;
                    err <= (n_pick > MAX_V) ? E_OVF : 2'b00;
                    state <= (n_pick > MAX_V) ? S_RESP : S_LAUNCH;
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                // a done seen in the first WAIT cycle may be left over from the previous run
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (fact_done && cnt != '0) begin
                        fn    <= fact_fn;
                        err   <= 2'b00;
                        state <= S_RESP;
                    end else if (cnt == CNT_END) begin
                        fn    <= '0;
                        err   <= E_TO;
                        state <= S_RESP;
                    end
                end
                default: begin
                    ptr   <= (id == IW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
